ocs_slot_scheduler: RTL and testbench

// - Timing master inside the OCS controller. Waits until every ToR control link is stable, then orders a

---
 rtl/ssrnet_pkg.sv | 27 ++
 rtl/link_stable_filter.sv | 40 ++++
 rtl/ocs_slot_scheduler.sv | 145 ++++++++++++++
 tb/tb_ocs_slot_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ssrnet_pkg.sv
// Shared types and default timing constants for the OCS slot scheduler.
package ssrnet_pkg;

   localparam int unsigned SLOT_MAX_BYTE_NUM = 32'h0000_4000;
   localparam int unsigned CONFIG_DELAY      = 32'h0000_00EA;
   localparam int unsigned SLOT_LEN          = 32'h0000_0927;
   localparam int unsigned LINK_STABLE       = 32'd256;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      SLOT  = 3'd2,
      RECFG = 3'd3,
      SYNC  = 3'd4
   } state_t;

   typedef enum logic {
      CMD_START = 1'b0,
      CMD_SYNC  = 1'b1
   } cmd_t;

   // A zero-length interval would never terminate; treat it as one cycle.
   function automatic int unsigned at_least_one(input int unsigned v);
      return (v == 32'd0) ? 32'd1 : v;
   endfunction

endpackage

// File: rtl/link_stable_filter.sv
// Asserts o_all_stable_c once every link has been up for P_LINK_STABLE consecutive cycles.
module link_stable_filter
   import ssrnet_pkg::*;
#(
   parameter int unsigned P_CHANNEL_NUM = 8,
   parameter int unsigned P_LINK_STABLE = LINK_STABLE
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [P_CHANNEL_NUM-1:0] i_link_up,
   input  logic                     i_en,
   output logic                     o_all_stable_c
);

   localparam int unsigned STABLE_C    = at_least_one(P_LINK_STABLE);
   localparam logic [31:0] STABLE_LAST = 32'(STABLE_C - 32'd1);

   logic        all_up_c;
   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   assign all_up_c = &i_link_up;

   // Count consecutive all-up cycles, saturating at the threshold; any drop restarts.
   always_comb begin
      cnt_d = '0;
      if (i_en && all_up_c) begin
         cnt_d = (cnt_q == STABLE_LAST) ? cnt_q : cnt_q + 32'd1;
      end
   end

   // Stability counter register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign o_all_stable_c = i_en && all_up_c && (cnt_q == STABLE_LAST);

endmodule

// File: rtl/ocs_slot_scheduler.sv
// OCS timing master: START after stable links, then fixed slots, reconfig gaps and SYNC commands.
module ocs_slot_scheduler
   import ssrnet_pkg::*;
#(
   parameter int unsigned P_CHANNEL_NUM  = 8,
   parameter int unsigned P_SLOT_ID_W    = 1,
   parameter int unsigned P_CONFIG_DELAY = CONFIG_DELAY,
   parameter int unsigned P_SLOT_LEN     = SLOT_LEN,
   parameter int unsigned P_LINK_STABLE  = LINK_STABLE
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [P_CHANNEL_NUM-1:0] i_link_up,
   output logic                     o_cmd_valid,
   input  logic                     i_cmd_ready,
   output logic                     o_cmd_type,
   output logic [P_SLOT_ID_W-1:0]   o_cmd_slot_id,
   output logic [P_SLOT_ID_W-1:0]   o_slot_id,
   output logic                     o_slot_active,
   output logic                     o_reconfig,
   output logic [31:0]              o_slot_cnt
);

   localparam logic [31:0] SLOT_LAST = 32'(at_least_one(P_SLOT_LEN) - 32'd1);
   localparam logic [31:0] CFG_LAST  = 32'(at_least_one(P_CONFIG_DELAY) - 32'd1);

   state_t                 state_q, state_d;
   logic [31:0]            cyc_q, cyc_d;
   logic [P_SLOT_ID_W-1:0] slot_id_q, slot_id_d;
   logic [31:0]            slot_cnt_q, slot_cnt_d;
   logic                   valid_q, valid_d;
   cmd_t                   type_q, type_d;
   logic [P_SLOT_ID_W-1:0] cmd_slot_id_q, cmd_slot_id_d;
   logic                   active_q, active_d;
   logic                   reconfig_q, reconfig_d;
   logic                   all_up_c;
   logic                   all_stable_c;

   assign all_up_c = &i_link_up;

   link_stable_filter #(
      .P_CHANNEL_NUM (P_CHANNEL_NUM),
      .P_LINK_STABLE (P_LINK_STABLE)
   ) u_link_stable_filter (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_link_up      (i_link_up),
      .i_en           (state_q == IDLE),
      .o_all_stable_c (all_stable_c)
   );

   // Next-state, counters and registered-output targets; link loss overrides everything.
   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      slot_id_d  = slot_id_q;
      slot_cnt_d = slot_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (all_stable_c) state_d = START;
         end
         START: begin
            if (valid_q && i_cmd_ready) begin
               state_d    = SLOT;
               slot_cnt_d = 32'd1;
               cyc_d      = '0;
            end
         end
         SLOT: begin
            if (cyc_q == SLOT_LAST) begin
               state_d   = RECFG;
               cyc_d     = '0;
               slot_id_d = slot_id_q + P_SLOT_ID_W'(1);
            end else begin
               cyc_d = cyc_q + 32'd1;
            end
         end
         RECFG: begin
            if (cyc_q == CFG_LAST) begin
               state_d = SYNC;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_q + 32'd1;
            end
         end
         SYNC: begin
            if (valid_q && i_cmd_ready) begin
               state_d    = SLOT;
               slot_cnt_d = slot_cnt_q + 32'd1;
               cyc_d      = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      // A dropped link aborts any activity, including an in-flight command.
      if ((state_q != IDLE) && !all_up_c) begin
         state_d    = IDLE;
         cyc_d      = '0;
         slot_id_d  = '0;
         slot_cnt_d = slot_cnt_q;
      end

      valid_d       = (state_d == START) || (state_d == SYNC);
      type_d        = (state_d == SYNC) ? CMD_SYNC : CMD_START;
      cmd_slot_id_d = slot_id_d;
      active_d      = (state_d == SLOT);
      reconfig_d    = (state_d == RECFG);
   end

   // State, counters and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= IDLE;
         cyc_q         <= '0;
         slot_id_q     <= '0;
         slot_cnt_q    <= '0;
         valid_q       <= 1'b0;
         type_q        <= CMD_START;
         cmd_slot_id_q <= '0;
         active_q      <= 1'b0;
         reconfig_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cyc_q         <= cyc_d;
         slot_id_q     <= slot_id_d;
         slot_cnt_q    <= slot_cnt_d;
         valid_q       <= valid_d;
         type_q        <= type_d;
         cmd_slot_id_q <= cmd_slot_id_d;
         active_q      <= active_d;
         reconfig_q    <= reconfig_d;
      end
   end

   assign o_cmd_valid   = valid_q;
   assign o_cmd_type    = type_q;
   assign o_cmd_slot_id = cmd_slot_id_q;
   assign o_slot_id     = slot_id_q;
   assign o_slot_active = active_q;
   assign o_reconfig    = reconfig_q;
   assign o_slot_cnt    = slot_cnt_q;

endmodule

// File: tb/tb_ocs_slot_scheduler.sv
// Directed bench for ocs_slot_scheduler with default timing (256 / 2343 / 234 cycles).
module tb_ocs_slot_scheduler;

   localparam int unsigned CH   = 8;
   localparam int unsigned IDW  = 1;
   localparam int unsigned CFG  = 234;
   localparam int unsigned SLEN = 2343;
   localparam int unsigned STAB = 256;

   logic           i_clk = 1'b0;
   logic           i_rst_n;
   logic [CH-1:0]  i_link_up;
   logic           i_cmd_ready;
   logic           o_cmd_valid;
   logic           o_cmd_type;
   logic [IDW-1:0] o_cmd_slot_id;
   logic [IDW-1:0] o_slot_id;
   logic           o_slot_active;
   logic           o_reconfig;
   logic [31:0]    o_slot_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 i_clk = ~i_clk;

   ocs_slot_scheduler #(
      .P_CHANNEL_NUM  (CH),
      .P_SLOT_ID_W    (IDW),
      .P_CONFIG_DELAY (CFG),
      .P_SLOT_LEN     (SLEN),
      .P_LINK_STABLE  (STAB)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_link_up     (i_link_up),
      .o_cmd_valid   (o_cmd_valid),
      .i_cmd_ready   (i_cmd_ready),
      .o_cmd_type    (o_cmd_type),
      .o_cmd_slot_id (o_cmd_slot_id),
      .o_slot_id     (o_slot_id),
      .o_slot_active (o_slot_active),
      .o_reconfig    (o_reconfig),
      .o_slot_cnt    (o_slot_cnt)
   );

   // Advance one clock and land 1 ns after the edge.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic count_active(output int n);
      n = 0;
      while (o_slot_active === 1'b1 && n < 5000) begin
         n++;
         step();
      end
   endtask

   task automatic count_reconfig(output int n);
      n = 0;
      while (o_reconfig === 1'b1 && n < 5000) begin
         n++;
         step();
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (o_cmd_valid !== 1'b1 && n < 2000) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      i_rst_n     = 1'b0;
      i_link_up   = '1;
      i_cmd_ready = 1'b1;
      #23;
      total_cnt++; if (o_cmd_valid !== 1'b0)   $display("FAIL reset_valid: got %0b want 0", o_cmd_valid); else pass_cnt++;
      total_cnt++; if (o_cmd_type !== 1'b0)    $display("FAIL reset_type: got %0b want 0", o_cmd_type); else pass_cnt++;
      total_cnt++; if (o_cmd_slot_id !== 1'b0) $display("FAIL reset_cmd_slot_id: got %0d want 0", o_cmd_slot_id); else pass_cnt++;
      total_cnt++; if (o_slot_id !== 1'b0)     $display("FAIL reset_slot_id: got %0d want 0", o_slot_id); else pass_cnt++;
      total_cnt++; if (o_slot_active !== 1'b0) $display("FAIL reset_active: got %0b want 0", o_slot_active); else pass_cnt++;
      total_cnt++; if (o_reconfig !== 1'b0)    $display("FAIL reset_reconfig: got %0b want 0", o_reconfig); else pass_cnt++;
      total_cnt++; if (o_slot_cnt !== 32'd0)   $display("FAIL reset_slot_cnt: got %0d want 0", o_slot_cnt); else pass_cnt++;
   endtask

   task automatic test_startup();
      int n;
      step();
      i_rst_n = 1'b1;
      wait_valid(n);
      total_cnt++; if (n != 256)               $display("FAIL start_latency: got %0d want 256", n); else pass_cnt++;
      total_cnt++; if (o_cmd_type !== 1'b0)    $display("FAIL start_type: got %0b want 0", o_cmd_type); else pass_cnt++;
      total_cnt++; if (o_cmd_slot_id !== 1'b0) $display("FAIL start_cmd_slot_id: got %0d want 0", o_cmd_slot_id); else pass_cnt++;
      step();
      total_cnt++; if (o_slot_active !== 1'b1) $display("FAIL start_active: got %0b want 1", o_slot_active); else pass_cnt++;
      total_cnt++; if (o_cmd_valid !== 1'b0)   $display("FAIL start_valid_drop: got %0b want 0", o_cmd_valid); else pass_cnt++;
      total_cnt++; if (o_slot_cnt !== 32'd1)   $display("FAIL start_slot_cnt: got %0d want 1", o_slot_cnt); else pass_cnt++;
      count_active(n);
      total_cnt++; if (n != 2343)              $display("FAIL slot1_len: got %0d want 2343", n); else pass_cnt++;
   endtask

   task automatic test_recfg();
      int n;
      total_cnt++; if (o_reconfig !== 1'b1)    $display("FAIL recfg_enter: got %0b want 1", o_reconfig); else pass_cnt++;
      total_cnt++; if (o_slot_id !== 1'b1)     $display("FAIL recfg_slot_id: got %0d want 1", o_slot_id); else pass_cnt++;
      count_reconfig(n);
      total_cnt++; if (n != 234)               $display("FAIL recfg_len: got %0d want 234", n); else pass_cnt++;
      total_cnt++; if (o_cmd_valid !== 1'b1)   $display("FAIL sync_valid: got %0b want 1", o_cmd_valid); else pass_cnt++;
      total_cnt++; if (o_cmd_type !== 1'b1)    $display("FAIL sync_type: got %0b want 1", o_cmd_type); else pass_cnt++;
      total_cnt++; if (o_cmd_slot_id !== 1'b1) $display("FAIL sync_cmd_slot_id: got %0d want 1", o_cmd_slot_id); else pass_cnt++;
      total_cnt++; if (o_slot_active !== 1'b0) $display("FAIL sync_active: got %0b want 0", o_slot_active); else pass_cnt++;
      step();
      total_cnt++; if (o_slot_active !== 1'b1) $display("FAIL slot2_active: got %0b want 1", o_slot_active); else pass_cnt++;
      total_cnt++; if (o_slot_cnt !== 32'd2)   $display("FAIL slot2_cnt: got %0d want 2", o_slot_cnt); else pass_cnt++;
   endtask

   task automatic test_wrap();
      int n;
      count_active(n);
      total_cnt++; if (n != 2343)              $display("FAIL slot2_len: got %0d want 2343", n); else pass_cnt++;
      total_cnt++; if (o_slot_id !== 1'b0)     $display("FAIL wrap_slot_id: got %0d want 0", o_slot_id); else pass_cnt++;
      count_reconfig(n);
      total_cnt++; if (n != 234)               $display("FAIL recfg2_len: got %0d want 234", n); else pass_cnt++;
      total_cnt++; if (o_cmd_slot_id !== 1'b0) $display("FAIL wrap_cmd_slot_id: got %0d want 0", o_cmd_slot_id); else pass_cnt++;
   endtask

   task automatic test_stall();
      int bad = 0;
      i_cmd_ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (!(o_cmd_valid === 1'b1 && o_cmd_type === 1'b1 && o_cmd_slot_id === 1'b0 &&
               o_slot_active === 1'b0 && o_reconfig === 1'b0)) bad++;
      end
      total_cnt++; if (bad != 0)               $display("FAIL stall_stable: got %0d bad cycles want 0", bad); else pass_cnt++;
      i_cmd_ready = 1'b1;
      step();
      total_cnt++; if (o_slot_active !== 1'b1) $display("FAIL stall_release_active: got %0b want 1", o_slot_active); else pass_cnt++;
      total_cnt++; if (o_slot_cnt !== 32'd3)   $display("FAIL stall_release_cnt: got %0d want 3", o_slot_cnt); else pass_cnt++;
   endtask

   task automatic test_link_drop_slot();
      int n;
      count_active(n);
      count_reconfig(n);
      step();
      total_cnt++; if (o_slot_cnt !== 32'd4)   $display("FAIL slot4_cnt: got %0d want 4", o_slot_cnt); else pass_cnt++;
      total_cnt++; if (o_slot_id !== 1'b1)     $display("FAIL slot4_id: got %0d want 1", o_slot_id); else pass_cnt++;
      repeat (100) step();
      i_link_up[2] = 1'b0;
      step();
      total_cnt++; if (o_slot_active !== 1'b0) $display("FAIL drop_active: got %0b want 0", o_slot_active); else pass_cnt++;
      total_cnt++; if (o_cmd_valid !== 1'b0)   $display("FAIL drop_valid: got %0b want 0", o_cmd_valid); else pass_cnt++;
      total_cnt++; if (o_slot_id !== 1'b0)     $display("FAIL drop_slot_id: got %0d want 0", o_slot_id); else pass_cnt++;
      total_cnt++; if (o_slot_cnt !== 32'd4)   $display("FAIL drop_slot_cnt_held: got %0d want 4", o_slot_cnt); else pass_cnt++;
      repeat (5) step();
      i_link_up[2] = 1'b1;
      wait_valid(n);
      total_cnt++; if (n != 256)               $display("FAIL drop_restart_latency: got %0d want 256", n); else pass_cnt++;
      total_cnt++; if (o_cmd_type !== 1'b0)    $display("FAIL drop_restart_type: got %0b want 0", o_cmd_type); else pass_cnt++;
      step();
      total_cnt++; if (o_slot_cnt !== 32'd1)   $display("FAIL restart_slot_cnt: got %0d want 1", o_slot_cnt); else pass_cnt++;
   endtask

   task automatic test_drop_on_sync();
      int n;
      count_active(n);
      count_reconfig(n);
      total_cnt++; if (o_cmd_valid !== 1'b1)   $display("FAIL sync_pre_drop_valid: got %0b want 1", o_cmd_valid); else pass_cnt++;
      i_link_up[2] = 1'b0;
      step();
      total_cnt++; if (o_cmd_valid !== 1'b0)   $display("FAIL syncdrop_valid: got %0b want 0", o_cmd_valid); else pass_cnt++;
      total_cnt++; if (o_slot_active !== 1'b0) $display("FAIL syncdrop_active: got %0b want 0", o_slot_active); else pass_cnt++;
      total_cnt++; if (o_slot_id !== 1'b0)     $display("FAIL syncdrop_slot_id: got %0d want 0", o_slot_id); else pass_cnt++;
      total_cnt++; if (o_slot_cnt !== 32'd1)   $display("FAIL syncdrop_slot_cnt: got %0d want 1", o_slot_cnt); else pass_cnt++;
      repeat (3) step();
      i_link_up[2] = 1'b1;
   endtask

   task automatic test_idle_glitch();
      int n;
      repeat (200) step();
      total_cnt++; if (o_cmd_valid !== 1'b0)   $display("FAIL glitch_early_valid: got %0b want 0", o_cmd_valid); else pass_cnt++;
      i_link_up[5] = 1'b0;
      step();
      i_link_up[5] = 1'b1;
      wait_valid(n);
      total_cnt++; if (n != 256)               $display("FAIL glitch_restart_latency: got %0d want 256", n); else pass_cnt++;
      step();
   endtask

   task automatic test_async_reset();
      int n;
      count_active(n);
      total_cnt++; if (o_reconfig !== 1'b1)    $display("FAIL prereset_reconfig: got %0b want 1", o_reconfig); else pass_cnt++;
      repeat (100) step();
      #2 i_rst_n = 1'b0;
      #1;
      total_cnt++; if (o_reconfig !== 1'b0)    $display("FAIL areset_reconfig: got %0b want 0", o_reconfig); else pass_cnt++;
      total_cnt++; if (o_slot_id !== 1'b0)     $display("FAIL areset_slot_id: got %0d want 0", o_slot_id); else pass_cnt++;
      total_cnt++; if (o_slot_cnt !== 32'd0)   $display("FAIL areset_slot_cnt: got %0d want 0", o_slot_cnt); else pass_cnt++;
      step();
      step();
      i_rst_n = 1'b1;
      wait_valid(n);
      total_cnt++; if (n != 256)               $display("FAIL areset_restart_latency: got %0d want 256", n); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_startup();
      test_recfg();
      test_wrap();
      test_stall();
      test_link_drop_slot();
      test_drop_on_sync();
      test_idle_glitch();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
